conv_mac_engine: RTL

//  Downstream compute stage of the accelerator: consumes the filter coefficient buffer and one

---
 rtl/conv_mac_engine_pkg.sv | 13 +
 rtl/conv_round_sat.sv | 32 +++
 rtl/conv_mac_engine.sv | 135 +++++++++++++
 3 files changed

// File: rtl/conv_mac_engine_pkg.sv
// Shared types and constants for the convolution MAC engine and its accelerator neighbours.
package conv_mac_engine_pkg;

  localparam int AcclDataWidth   = 32;
  localparam int NumFilterCoeffs = 9;
  localparam int AcclFracBits    = 16;
  localparam int AcclAccWidth    = 72;

  typedef logic signed [AcclDataWidth-1:0] AcclDataType;

  typedef enum logic [1:0] {MAC_IDLE, MAC_RUN, MAC_ROUND, MAC_HOLD} MacStateType;

endpackage

// File: rtl/conv_round_sat.sv
// Rounds a Q-format accumulator half toward +inf, drops FRAC_BITS and saturates to DATA_W.
module conv_round_sat
  import conv_mac_engine_pkg::*;
#(
  parameter int ACC_W     = AcclAccWidth,
  parameter int DATA_W    = AcclDataWidth,
  parameter int FRAC_BITS = AcclFracBits
) (
  input  logic signed [ACC_W-1:0]  acc_i,
  output logic signed [DATA_W-1:0] result_o
);

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC_BITS - 1);

  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] shifted;
  logic [ACC_W-DATA_W:0]   hi;

  assign sum     = acc_i + HALF;
  assign shifted = sum >>> FRAC_BITS;
  // The value fits when every bit above the result's sign bit copies it.
  assign hi      = shifted[ACC_W-1:DATA_W-1];

  always_comb begin
    result_o = shifted[DATA_W-1:0];
    if (!((&hi) || (~|hi))) begin
      if (shifted[ACC_W-1]) result_o = {1'b1, {(DATA_W-1){1'b0}}};
      else                  result_o = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/conv_mac_engine.sv
// Single-multiplier signed dot product over one pixel window, one tap per cycle,
// with a rounded and saturated result on a valid/ready output.
module conv_mac_engine
  import conv_mac_engine_pkg::*;
#(
  parameter int DATA_W    = AcclDataWidth,
  parameter int NUM_TAPS  = NumFilterCoeffs,
  parameter int FRAC_BITS = AcclFracBits,
  parameter int ACC_W     = AcclAccWidth
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_i,
  input  logic                       start_i,
  input  logic [NUM_TAPS*DATA_W-1:0] coeff_i,
  input  logic [NUM_TAPS*DATA_W-1:0] pixel_i,
  output logic                       busy_o,
  output logic                       start_drop_o,
  output logic [DATA_W-1:0]          result_o,
  output logic                       result_valid_o,
  input  logic                       result_ready_i,
  output MacStateType                state_o
);

  localparam int TAP_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
  localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(NUM_TAPS - 1);

  // Handshake: the result transfers on a rising clk edge where result_valid_o and
  // result_ready_i are both high; valid and data never change while waiting for ready.

  MacStateType                state_q, state_d;
  logic [TAP_W-1:0]           tap_q, tap_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic [NUM_TAPS*DATA_W-1:0] coeff_q, coeff_d, pixel_q, pixel_d;
  logic [DATA_W-1:0]          result_q, result_d;
  logic                       valid_q, valid_d;
  logic                       drop;

  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;
  logic signed [DATA_W-1:0]   rounded;

  // Snapshots shift down one tap per MAC cycle, so tap k always sits in the low slice.
  assign prod     = $signed(coeff_q[DATA_W-1:0]) * $signed(pixel_q[DATA_W-1:0]);
  assign prod_ext = {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};

  conv_round_sat #(
    .ACC_W    (ACC_W),
    .DATA_W   (DATA_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_round_sat (
    .acc_i   (acc_q),
    .result_o(rounded)
  );

  always_comb begin
    state_d  = state_q;
    tap_d    = tap_q;
    acc_d    = acc_q;
    coeff_d  = coeff_q;
    pixel_d  = pixel_q;
    result_d = result_q;
    valid_d  = valid_q;
    drop     = 1'b0;
    unique case (state_q)
      MAC_IDLE: begin
        if (start_i) begin
          coeff_d = coeff_i;
          pixel_d = pixel_i;
          acc_d   = '0;
          tap_d   = '0;
          state_d = MAC_RUN;
        end
      end
      MAC_RUN: begin
        drop    = start_i;
        acc_d   = acc_q + prod_ext;
        coeff_d = coeff_q >> DATA_W;
        pixel_d = pixel_q >> DATA_W;
        if (tap_q == LAST_TAP) state_d = MAC_ROUND;
        else                   tap_d   = tap_q + 1'b1;
      end
      MAC_ROUND: begin
        drop     = start_i;
        result_d = rounded;
        valid_d  = 1'b1;
        state_d  = MAC_HOLD;
      end
      MAC_HOLD: begin
        if (result_ready_i) begin
          valid_d = 1'b0;
          if (start_i) begin
            coeff_d = coeff_i;
            pixel_d = pixel_i;
            acc_d   = '0;
            tap_d   = '0;
            state_d = MAC_RUN;
          end else begin
            state_d = MAC_IDLE;
          end
        end else begin
          drop = start_i;
        end
      end
      default: state_d = MAC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      state_q  <= MAC_IDLE;
      tap_q    <= '0;
      acc_q    <= '0;
      coeff_q  <= '0;
      pixel_q  <= '0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      tap_q    <= tap_d;
      acc_q    <= acc_d;
      coeff_q  <= coeff_d;
      pixel_q  <= pixel_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign busy_o         = (state_q != MAC_IDLE);
  assign start_drop_o   = drop && !(rst || clear_i);
  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign state_o        = state_q;

endmodule
